// File: rtl/spiral_unroll.sv
// spiral_unroll
//   Buffers one row x col matrix that arrives in clockwise spiral order and
//   re-emits it in raster order. Fill and drain never overlap: the whole
//   matrix is written first, then read out, then the block returns to idle.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   row, col       matrix dimensions, sampled on the first accepted input beat
//   data_in        element in spiral order
//   data_in_valid  data_in is valid
//   data_in_rdy    block accepts data_in this cycle
//   data_out       element in raster order
//   data_out_valid data_out is valid
//   data_out_rdy   downstream accepts data_out
module spiral_unroll #(
    parameter int DATA_WIDTH = 8,
    parameter int R_WIDTH    = 3,
    parameter int C_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [R_WIDTH-1:0]    row,
    input  logic [C_WIDTH-1:0]    col,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_rdy
);

    localparam int AW = R_WIDTH + C_WIDTH;
    // Walk coordinates and bounds carry one extra bit so the final
    // decrement past zero does not alias a valid position.
    localparam int RB = R_WIDTH + 1;
    localparam int CB = C_WIDTH + 1;

    localparam logic [RB-1:0] R_ONE   = RB'(1);
    localparam logic [CB-1:0] C_ONE   = CB'(1);
    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    typedef enum logic [1:0] {DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP} dir_t;

    typedef struct packed {
        logic [RB-1:0] r;
        logic [CB-1:0] c;
        logic [RB-1:0] top;
        logic [RB-1:0] bot;
        logic [CB-1:0] left;
        logic [CB-1:0] right;
        dir_t          dir;
    } walk_t;

    // One step of the clockwise spiral from the current position.
    function automatic walk_t walk_step(input walk_t w);
        walk_t n;
        n = w;
        case (w.dir)
            DIR_RIGHT: begin
                if (w.c < w.right) begin
                    n.c = w.c + C_ONE;
                end else begin
                    n.top = w.top + R_ONE;
                    n.r   = w.r + R_ONE;
                    n.dir = DIR_DOWN;
                end
            end
            DIR_DOWN: begin
                if (w.r < w.bot) begin
                    n.r = w.r + R_ONE;
                end else begin
                    n.right = w.right - C_ONE;
                    n.c     = w.c - C_ONE;
                    n.dir   = DIR_LEFT;
                end
            end
            DIR_LEFT: begin
                if (w.c > w.left) begin
                    n.c = w.c - C_ONE;
                end else begin
                    n.bot = w.bot - R_ONE;
                    n.r   = w.r - R_ONE;
                    n.dir = DIR_UP;
                end
            end
            default: begin
                if (w.r > w.top) begin
                    n.r = w.r - R_ONE;
                end else begin
                    n.left = w.left + C_ONE;
                    n.c    = w.c + C_ONE;
                    n.dir  = DIR_RIGHT;
                end
            end
        endcase
        return n;
    endfunction

    state_t                state_q, state_d;
    walk_t                 walk_q, walk_init, walk_cur, walk_nxt;
    logic [C_WIDTH-1:0]    c_len;
    logic [AW-1:0]         n_total;
    logic [AW-1:0]         wr_cnt;
    logic [AW-1:0]         rd_cnt;
    logic [R_WIDTH-1:0]    rd_r;
    logic [C_WIDTH-1:0]    rd_c;
    logic [AW-1:0]         n_in;
    logic                  in_beat, out_beat;

    logic [DATA_WIDTH-1:0] mem [2**AW];

    assign in_beat  = data_in_valid & data_in_rdy;
    assign out_beat = data_out_valid & data_out_rdy;
    assign n_in     = AW'(row) * AW'(col);

    // In IDLE the walk starts from a freshly initialised spiral so the first
    // beat writes (0,0) and the registered walk already points at element 2.
    always_comb begin
        walk_init       = '0;
        walk_init.bot   = RB'(row) - R_ONE;
        walk_init.right = CB'(col) - C_ONE;
        walk_init.dir   = DIR_RIGHT;
        walk_cur        = (state_q == IDLE) ? walk_init : walk_q;
        walk_nxt        = walk_step(walk_cur);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_beat) begin
                    state_d = (n_in == CNT_ONE) ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (in_beat && (wr_cnt + CNT_ONE == n_total)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_beat && (rd_cnt + CNT_ONE == n_total)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; both handshakes are held low while reset is asserted.
    always_comb begin
        data_in_rdy    = 1'b0;
        data_out_valid = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    data_in_rdy    = (row != '0) && (col != '0);
                FILL:    data_in_rdy    = 1'b1;
                DRAIN:   data_out_valid = 1'b1;
                default: data_in_rdy    = 1'b0;
            endcase
        end
    end

    // Walk, counters and raster read pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            walk_q  <= '0;
            c_len   <= '0;
            n_total <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rd_r    <= '0;
            rd_c    <= '0;
        end else begin
            if (in_beat) begin
                walk_q <= walk_nxt;
                if (state_q == IDLE) begin
                    c_len   <= col;
                    n_total <= n_in;
                    wr_cnt  <= CNT_ONE;
                    rd_cnt  <= '0;
                    rd_r    <= '0;
                    rd_c    <= '0;
                end else begin
                    wr_cnt <= wr_cnt + CNT_ONE;
                end
            end
            if (out_beat) begin
                rd_cnt <= rd_cnt + CNT_ONE;
                if (rd_c == c_len - C_WIDTH'(1)) begin
                    rd_c <= '0;
                    rd_r <= rd_r + R_WIDTH'(1);
                end else begin
                    rd_c <= rd_c + C_WIDTH'(1);
                end
            end
        end
    end

    // Matrix storage, addressed {row, col}; contents are not reset.
    always_ff @(posedge clk) begin
        if (in_beat) begin
            mem[{walk_cur.r[R_WIDTH-1:0], walk_cur.c[C_WIDTH-1:0]}] <= data_in;
        end
    end

    assign data_out = mem[{rd_r, rd_c}];

endmodule

// File: tb/tb_spiral_unroll.sv
// Testbench for spiral_unroll: drives spiral-ordered matrices and compares the
// raster output against a visited-grid spiral model.
module tb_spiral_unroll;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_rdy;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_rdy;

    spiral_unroll #(.DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .row            (row),
        .col            (col),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_rdy    (data_in_rdy),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_rdy   (data_out_rdy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int   got_q[$];
    int   exp_q[$];
    int   vals[64];
    int   last_out_cyc = 0;
    int   vld_cycles   = 0;
    bit   stall_en     = 1'b0;
    int   first_in_cyc;
    int   prev_out_cyc;
    int   got_at_first;

    // Output monitor
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else if (data_out_valid) begin
                vld_cycles++;
                chk("in_rdy_in_drain", {31'd0, data_in_rdy}, 32'd0);
                if (prev_stall) chk("hold_stable", {24'd0, data_out}, {24'd0, prev_data});
                if (data_out_rdy) begin
                    got_q.push_back(int'(data_out));
                    last_out_cyc = cyc + 1;
                    prev_stall   = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = data_out;
                end
            end else begin
                if (prev_stall) chk("valid_held", {31'd0, data_out_valid}, 32'd1);
                prev_stall = 1'b0;
            end
        end
    end

    // Downstream ready
    initial begin
        data_out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            data_out_rdy = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Reference: walk a grid turning clockwise on hitting an edge or a
    // visited cell, place vals in that order, then read out row by row.
    task automatic build_exp(input int R, input int C);
        int vis[8][8];
        int mat[8][8];
        int dr[4];
        int dc[4];
        int r, c, d, nr, nc;
        dr = '{0, 1, 0, -1};
        dc = '{1, 0, -1, 0};
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                vis[i][j] = 0;
                mat[i][j] = 0;
            end
        r = 0; c = 0; d = 0;
        for (int k = 0; k < R * C; k++) begin
            mat[r][c] = vals[k];
            vis[r][c] = 1;
            nr = r + dr[d];
            nc = c + dc[d];
            if (nr < 0 || nr >= R || nc < 0 || nc >= C || vis[nr][nc] != 0) begin
                d  = (d + 1) % 4;
                nr = r + dr[d];
                nc = c + dc[d];
            end
            r = nr;
            c = nc;
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                exp_q.push_back(mat[i][j]);
    endtask

    task automatic send_mat(input int R, input int C, input int nbeats, input bit gaps);
        int  waited;
        bit  accepted;
        row = RW'(R);
        col = CW'(C);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    data_in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            data_in       = DW'(vals[k]);
            data_in_valid = 1'b1;
            waited        = 0;
            accepted      = 1'b0;
            while (!accepted) begin
                @(negedge clk);
                if (data_in_rdy) accepted = 1'b1;
                @(posedge clk);
                #1;
                if (!accepted) begin
                    waited++;
                    if (waited > 300) begin
                        chk("in_timeout", 32'd0, 32'd1);
                        data_in_valid = 1'b0;
                        return;
                    end
                end
            end
            if (k == 0) begin
                first_in_cyc = cyc;
                prev_out_cyc = last_out_cyc;
                got_at_first = got_q.size();
            end
        end
        data_in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int w;
        w = 0;
        while (got_q.size() < n && w < 2000) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("out_count", got_q.size(), n);
    endtask

    task automatic cmp_out(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk(tag, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_mat(input string tag, input int R, input int C, input bit gaps);
        exp_q.delete();
        build_exp(R, C);
        send_mat(R, C, R * C, gaps);
        wait_out(R * C);
        cmp_out(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int lit33[9];
        int lit24[8];
        int R, C;
        lit33 = '{1, 2, 3, 8, 9, 4, 7, 6, 5};
        lit24 = '{1, 2, 3, 4, 8, 7, 6, 5};

        rst = 1'b1; row = '0; col = '0; data_in = '0; data_in_valid = 1'b0;
        row = 3'd3; col = 3'd3; data_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_rdy", {31'd0, data_in_rdy}, 32'd0);
        chk("reset_out_valid", {31'd0, data_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_rdy", {31'd0, data_in_rdy}, 32'd1);
        chk("idle_out_valid", {31'd0, data_out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // 3x3 against literal and model; valid high for exactly 9 cycles
        for (int k = 0; k < 9; k++) vals[k] = k + 1;
        vld_cycles = 0;
        exp_q.delete();
        build_exp(3, 3);
        send_mat(3, 3, 9, 1'b0);
        wait_out(9);
        for (int i = 0; i < 9; i++) if (i < got_q.size()) chk("m3x3_lit", got_q[i], lit33[i]);
        chk("m3x3_vld_cycles", vld_cycles, 9);
        cmp_out("m3x3");

        // 2x4
        for (int k = 0; k < 8; k++) vals[k] = k + 1;
        exp_q.delete();
        build_exp(2, 4);
        send_mat(2, 4, 8, 1'b0);
        wait_out(8);
        for (int i = 0; i < 8; i++) if (i < got_q.size()) chk("m2x4_lit", got_q[i], lit24[i]);
        cmp_out("m2x4");

        // 4x1 and 1x1
        for (int k = 0; k < 4; k++) vals[k] = k + 1;
        run_mat("m4x1", 4, 1, 1'b0);
        vals[0] = 8'hA5;
        run_mat("m1x1", 1, 1, 1'b0);

        // 7x5 with input gaps and output stalls
        for (int k = 0; k < 35; k++) vals[k] = k + 1;
        stall_en = 1'b1;
        run_mat("m7x5", 7, 5, 1'b1);

        // Random shapes and data
        for (int t = 0; t < 6; t++) begin
            R = $urandom_range(1, 7);
            C = $urandom_range(1, 7);
            for (int k = 0; k < R * C; k++) vals[k] = $urandom_range(0, 255);
            run_mat("rand", R, C, 1'b1);
        end
        stall_en = 1'b0;

        // Zero dimension: never ready, never outputs
        row = 3'd0; col = 3'd5; data_in = 8'h77; data_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 0) begin
                chk("zero_in_rdy", {31'd0, data_in_rdy}, 32'd0);
                chk("zero_out_valid", {31'd0, data_out_valid}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        chk("zero_no_out", got_q.size(), 0);

        // Reset mid-fill, then a clean 3x3
        for (int k = 0; k < 35; k++) vals[k] = 100 + k;
        send_mat(7, 5, 10, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_out", got_q.size(), 0);
        for (int k = 0; k < 9; k++) vals[k] = k + 1;
        exp_q.delete();
        send_mat(3, 3, 9, 1'b0);
        wait_out(9);
        for (int i = 0; i < 9; i++) if (i < got_q.size()) chk("after_rst_lit", got_q[i], lit33[i]);
        got_q.delete();

        // Back-to-back 3x3 then 2x4
        exp_q.delete();
        for (int k = 0; k < 9; k++) vals[k] = k + 1;
        build_exp(3, 3);
        send_mat(3, 3, 9, 1'b0);
        for (int k = 0; k < 8; k++) vals[k] = 20 + k;
        build_exp(2, 4);
        send_mat(2, 4, 8, 1'b0);
        chk("b2b_turnaround", first_in_cyc, prev_out_cyc + 1);
        chk("b2b_after_9", got_at_first, 9);
        wait_out(17);
        cmp_out("b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
